// File: rtl/cond_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// cond_pc_unit_pkg
//
// Purpose:
//   Shared definitions for the Execute-stage PC-select / condition logic.
//   Contents:
//     - the 4-bit ARM condition-code encodings;
//     - the bit positions of N, Z, C and V inside a {N,Z,C,V} flags word;
//     - the default register index that aliases the PC.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package cond_pc_unit_pkg;

   // ARM condition field encodings
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Bit positions inside the {N,Z,C,V} flags word
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Register index that aliases the program counter
   localparam int PC_REG_DEFAULT = 15;

endpackage : cond_pc_unit_pkg

// File: rtl/cond_pc_unit_cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
//
// Purpose:
//   Purely combinational evaluation of an ARM condition field against a
//   {N,Z,C,V} flags word. Shared with the predicated-ALU path.
//
// Ports:
//   cond     in  4  instruction condition field
//   flags    in  4  {N,Z,C,V}
//   cond_ex  out 1  1 when the instruction should execute
// -----------------------------------------------------------------------------
module cond_check
   import cond_pc_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n;
   logic z;
   logic c;
   logic v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      cond_ex = 1'b0;
      unique case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         COND_NV: cond_ex = 1'b0;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule : cond_check

// File: rtl/cond_pc_unit.sv
// -----------------------------------------------------------------------------
// cond_pc_unit
//
// Purpose:
//   Execute-stage PC-select and conditional-execution unit. Qualifies the
//   decoder's write/branch requests with the condition code, selects the next
//   PC source, keeps the NZCV flags register, squashes the wrong-path
//   instructions that follow a taken PC write, and counts taken PC writes.
//
// Ports:
//   clk          in   1           rising-edge clock
//   reset        in   1           synchronous active-high reset
//   advance      in   1           pipeline moved this cycle; gates all state
//   valid_e      in   1           Execute slot holds a real instruction
//   rd           in   REG_ADDR_W  destination register
//   reg_w        in   1           decoder register-write request
//   mem_w        in   1           decoder memory-write request
//   branch       in   1           decoder branch request
//   flag_w       in   2           [1] update N,Z ; [0] update C,V
//   cond         in   4           condition field
//   alu_flags    in   4           {N,Z,C,V} from the ALU
//   pc_src       out  1           take branch/ALU result as next PC
//   reg_write    out  1           qualified register-file write enable
//   mem_write    out  1           qualified data-memory write enable
//   flush        out  1           kill younger pipeline stages
//   flags        out  4           registered {N,Z,C,V}
//   taken_count  out  CNT_W       taken PC writes since reset (wraps)
// -----------------------------------------------------------------------------
module cond_pc_unit
   import cond_pc_unit_pkg::*;
#(
   parameter int REG_ADDR_W  = 4,
   parameter int PC_REG      = PC_REG_DEFAULT,
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  advance,
   input  logic                  valid_e,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic                  reg_w,
   input  logic                  mem_w,
   input  logic                  branch,
   input  logic [1:0]            flag_w,
   input  logic [3:0]            cond,
   input  logic [3:0]            alu_flags,
   output logic                  pc_src,
   output logic                  reg_write,
   output logic                  mem_write,
   output logic                  flush,
   output logic [3:0]            flags,
   output logic [CNT_W-1:0]      taken_count
);

   localparam int                    FC_W       = $clog2(FLUSH_DEPTH + 1);
   localparam logic [FC_W-1:0]       FLUSH_LOAD = FC_W'(FLUSH_DEPTH);
   localparam logic [REG_ADDR_W-1:0] PC_ADDR    = REG_ADDR_W'(PC_REG);

   logic [3:0]       flags_q;
   logic [FC_W-1:0]  flush_cnt;
   logic [CNT_W-1:0] taken_q;

   logic pcs;
   logic cond_ex;
   logic squash;
   logic ok;

   cond_check u_cond_check (
      .cond    (cond),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

   // A write to the PC register is a PC write just like an explicit branch.
   assign pcs    = ((rd == PC_ADDR) & reg_w) | branch;
   assign squash = (flush_cnt != '0);
   assign ok     = valid_e & ~squash & cond_ex;

   // reg_write stays asserted on a PC write; the register file drops writes
   // to the PC index and the fetch mux takes the value via pc_src.
   assign pc_src    = ok & pcs;
   assign reg_write = ok & reg_w;
   assign mem_write = ok & mem_w;
   assign flush     = pc_src | squash;

   assign flags       = flags_q;
   assign taken_count = taken_q;

   // Flags: the N,Z and C,V halves load independently. cond_check sees the
   // registered value, so a flag-setting instruction affects only later ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= 4'b0000;
      end else if (advance && ok) begin
         if (flag_w[1]) begin
            flags_q[FLAG_N] <= alu_flags[FLAG_N];
            flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
         end
         if (flag_w[0]) begin
            flags_q[FLAG_C] <= alu_flags[FLAG_C];
            flags_q[FLAG_V] <= alu_flags[FLAG_V];
         end
      end
   end

   // Squash window: pc_src is already masked by squash, so the load and the
   // decrement branches are mutually exclusive.
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_cnt <= '0;
      end else if (advance && pc_src) begin
         flush_cnt <= FLUSH_LOAD;
      end else if (advance && squash) begin
         flush_cnt <= flush_cnt - FC_W'(1);
      end
   end

   // Taken PC-write counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (reset) begin
         taken_q <= '0;
      end else if (advance && pc_src) begin
         taken_q <= taken_q + CNT_W'(1);
      end
   end

endmodule : cond_pc_unit

// File: tb/tb_cond_pc_unit.sv
module tb_cond_pc_unit;

   logic       clk;
   logic       reset;
   logic       advance;
   logic       valid_e;
   logic [3:0] rd;
   logic       reg_w;
   logic       mem_w;
   logic       branch;
   logic [1:0] flag_w;
   logic [3:0] cond;
   logic [3:0] alu_flags;

   logic        pc_src, reg_write, mem_write, flush;
   logic [3:0]  flags;
   logic [15:0] taken_count;

   logic        pc_src_w, reg_write_w, mem_write_w, flush_w;
   logic [3:0]  flags_w;
   logic [1:0]  taken_count_w;

   int checks;
   int errors;

   cond_pc_unit #(
      .REG_ADDR_W (4), .PC_REG (15), .FLUSH_DEPTH (2), .CNT_W (16)
   ) u_dut (
      .clk (clk), .reset (reset), .advance (advance), .valid_e (valid_e),
      .rd (rd), .reg_w (reg_w), .mem_w (mem_w), .branch (branch),
      .flag_w (flag_w), .cond (cond), .alu_flags (alu_flags),
      .pc_src (pc_src), .reg_write (reg_write), .mem_write (mem_write),
      .flush (flush), .flags (flags), .taken_count (taken_count)
   );

   // Narrow-counter instance for the wrap-around case; shares all inputs.
   cond_pc_unit #(
      .REG_ADDR_W (4), .PC_REG (15), .FLUSH_DEPTH (2), .CNT_W (2)
   ) u_dut_w (
      .clk (clk), .reset (reset), .advance (advance), .valid_e (valid_e),
      .rd (rd), .reg_w (reg_w), .mem_w (mem_w), .branch (branch),
      .flag_w (flag_w), .cond (cond), .alu_flags (alu_flags),
      .pc_src (pc_src_w), .reg_write (reg_write_w), .mem_write (mem_write_w),
      .flush (flush_w), .flags (flags_w), .taken_count (taken_count_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Reference condition table, organised by the ARM pairing (odd = inverse).
   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'b1111) return 1'b0;
      return c[0] ? !base : base;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      advance   = 1'b1;
      valid_e   = 1'b0;
      rd        = 4'd0;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      branch    = 1'b0;
      flag_w    = 2'b00;
      cond      = 4'b1110;
      alu_flags = 4'b0000;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      valid_e = 1'b1; cond = 4'b1110; rd = 4'd3; reg_w = 1'b1;
      settle();
      checks++;
      if (reg_write !== 1'b1) begin
         errors++; $display("FAIL reset_reg_write got %b want 1", reg_write);
      end
      checks++;
      if (pc_src !== 1'b0 || flush !== 1'b0) begin
         errors++; $display("FAIL reset_pc_flush got pc_src=%b flush=%b want 0 0", pc_src, flush);
      end
      checks++;
      if (flags !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b want 0000", flags);
      end
      checks++;
      if (taken_count !== 16'd0 || taken_count_w !== 2'd0) begin
         errors++; $display("FAIL reset_count got %0d/%0d want 0/0", taken_count, taken_count_w);
      end
      tick();
   endtask

   task automatic test_taken_branch();
      idle();
      valid_e = 1'b1; flag_w = 2'b10; alu_flags = 4'b0100;
      tick();
      checks++;
      if (flags !== 4'b0100) begin
         errors++; $display("FAIL tb_set_z got %b want 0100", flags);
      end
      flag_w = 2'b00; cond = 4'b0000; branch = 1'b1;
      settle();
      checks++;
      if (pc_src !== 1'b1 || flush !== 1'b1) begin
         errors++; $display("FAIL tb_eq_taken got pc_src=%b flush=%b want 1 1", pc_src, flush);
      end
      tick();
      // Two squashed slots carrying write and flag requests
      branch = 1'b0; cond = 4'b1110; reg_w = 1'b1; mem_w = 1'b1;
      flag_w = 2'b11; alu_flags = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         settle();
         checks++;
         if (flush !== 1'b1 || pc_src !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL tb_squash_slot%0d got flush=%b pc=%b rw=%b mw=%b want 1 0 0 0",
                     i, flush, pc_src, reg_write, mem_write);
         end
         tick();
      end
      flag_w = 2'b00;
      settle();
      checks++;
      if (flush !== 1'b0 || reg_write !== 1'b1 || mem_write !== 1'b1) begin
         errors++; $display("FAIL tb_after_squash got flush=%b rw=%b mw=%b want 0 1 1", flush, reg_write, mem_write);
      end
      checks++;
      if (taken_count !== 16'd1) begin
         errors++; $display("FAIL tb_count got %0d want 1", taken_count);
      end
      checks++;
      if (flags !== 4'b0100) begin
         errors++; $display("FAIL tb_squash_flags got %b want 0100", flags);
      end
      tick();
   endtask

   task automatic test_not_taken();
      idle();
      valid_e = 1'b1; cond = 4'b0001; branch = 1'b1;
      settle();
      checks++;
      if (pc_src !== 1'b0 || flush !== 1'b0) begin
         errors++; $display("FAIL nt_ne got pc_src=%b flush=%b want 0 0", pc_src, flush);
      end
      tick();
      checks++;
      if (taken_count !== 16'd1) begin
         errors++; $display("FAIL nt_count got %0d want 1", taken_count);
      end
      branch = 1'b0; cond = 4'b1110; rd = 4'd15; reg_w = 1'b1;
      settle();
      checks++;
      if (pc_src !== 1'b1 || reg_write !== 1'b1 || flush !== 1'b1) begin
         errors++; $display("FAIL nt_pc_write got pc=%b rw=%b flush=%b want 1 1 1", pc_src, reg_write, flush);
      end
      tick();
      idle();
      tick();
      tick();
      checks++;
      if (taken_count !== 16'd2 || flush !== 1'b0) begin
         errors++; $display("FAIL nt_drain got count=%0d flush=%b want 2 0", taken_count, flush);
      end
   endtask

   task automatic test_stall();
      idle();
      valid_e = 1'b1; branch = 1'b1;
      tick();
      advance = 1'b0; branch = 1'b0; reg_w = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++;
         if (flush !== 1'b1 || reg_write !== 1'b0) begin
            errors++; $display("FAIL stall_hold%0d got flush=%b rw=%b want 1 0", i, flush, reg_write);
         end
         tick();
      end
      checks++;
      if (taken_count !== 16'd3) begin
         errors++; $display("FAIL stall_count got %0d want 3", taken_count);
      end
      advance = 1'b1;
      for (int i = 0; i < 2; i++) begin
         settle();
         checks++;
         if (flush !== 1'b1) begin
            errors++; $display("FAIL stall_resume%0d got flush=%b want 1", i, flush);
         end
         tick();
      end
      settle();
      checks++;
      if (flush !== 1'b0 || reg_write !== 1'b1) begin
         errors++; $display("FAIL stall_end got flush=%b rw=%b want 0 1", flush, reg_write);
      end
      // Stalled cycle: outputs still follow inputs, state holds.
      advance = 1'b0; branch = 1'b1;
      settle();
      checks++;
      if (pc_src !== 1'b1) begin
         errors++; $display("FAIL stall_comb_pc got %b want 1", pc_src);
      end
      tick();
      branch = 1'b0;
      settle();
      checks++;
      if (flush !== 1'b0 || taken_count !== 16'd3) begin
         errors++; $display("FAIL stall_no_load got flush=%b count=%0d want 0 3", flush, taken_count);
      end
      idle();
      tick();
   endtask

   task automatic test_cond_sweep();
      logic [3:0] s;
      logic [3:0] c;
      logic       exp;
      for (int si = 0; si < 16; si++) begin
         s = 4'(si);
         idle();
         valid_e = 1'b1; flag_w = 2'b11; alu_flags = s;
         tick();
         checks++;
         if (flags !== s) begin
            errors++; $display("FAIL sweep_load got %b want %b", flags, s);
         end
         advance = 1'b0; flag_w = 2'b00; reg_w = 1'b1;
         for (int ci = 0; ci < 16; ci++) begin
            c = 4'(ci);
            cond = c;
            exp = ref_cond(c, s);
            settle();
            checks++;
            if (reg_write !== exp) begin
               errors++; $display("FAIL sweep_cond c=%b f=%b got %b want %b", c, s, reg_write, exp);
            end
         end
      end
      idle();
      valid_e = 1'b1; flag_w = 2'b11; alu_flags = 4'b0000;
      tick();
      flag_w = 2'b01; alu_flags = 4'b1111;
      tick();
      checks++;
      if (flags !== 4'b0011) begin
         errors++; $display("FAIL half_cv got %b want 0011", flags);
      end
      flag_w = 2'b11; alu_flags = 4'b0000; cond = 4'b1111;
      tick();
      checks++;
      if (flags !== 4'b0011) begin
         errors++; $display("FAIL nv_no_update got %b want 0011", flags);
      end
      flag_w = 2'b10; alu_flags = 4'b1100; cond = 4'b1110;
      tick();
      checks++;
      if (flags !== 4'b1111) begin
         errors++; $display("FAIL half_nz got %b want 1111", flags);
      end
      idle();
      tick();
   endtask

   task automatic test_reset_mid_squash();
      idle();
      valid_e = 1'b1; branch = 1'b1;
      tick();
      idle();
      reset = 1'b1;
      settle();
      checks++;
      if (flush !== 1'b1) begin
         errors++; $display("FAIL rms_before got flush=%b want 1", flush);
      end
      tick();
      reset = 1'b0;
      settle();
      checks++;
      if (flush !== 1'b0 || flags !== 4'b0000 || taken_count !== 16'd0) begin
         errors++; $display("FAIL rms_after got flush=%b flags=%b count=%0d want 0 0000 0", flush, flags, taken_count);
      end
   endtask

   task automatic test_back_to_back_wrap();
      for (int i = 0; i < 5; i++) begin
         idle();
         valid_e = 1'b1; rd = 4'd15; reg_w = 1'b1;
         tick();
         idle();
         tick();
         tick();
      end
      settle();
      checks++;
      if (taken_count_w !== 2'd1) begin
         errors++; $display("FAIL wrap_count2 got %0d want 1", taken_count_w);
      end
      checks++;
      if (taken_count !== 16'd5) begin
         errors++; $display("FAIL wrap_count16 got %0d want 5", taken_count);
      end
      valid_e = 1'b1; mem_w = 1'b1; branch = 1'b1;
      settle();
      checks++;
      if (pc_src_w !== 1'b1 || reg_write_w !== 1'b0 || mem_write_w !== 1'b1 ||
          flush_w !== 1'b1 || flags_w !== 4'b0000) begin
         errors++; $display("FAIL wrap_outputs got pc=%b rw=%b mw=%b fl=%b flags=%b want 1 0 1 1 0000",
                            pc_src_w, reg_write_w, mem_write_w, flush_w, flags_w);
      end
      tick();
      idle();
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle();
      test_reset();
      test_taken_branch();
      test_not_taken();
      test_stall();
      test_cond_sweep();
      test_reset_mid_squash();
      test_back_to_back_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_cond_pc_unit
